// File: rtl/rssi_pkg.sv
// Shared types for the RSSI band sequencer: sample type, FSM states and the
// one-hot result encoding produced by the shared magnitude comparator.
package rssi_pkg;

    localparam int RSSI_W = 6;

    typedef logic [RSSI_W-1:0] rssi_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit 2 gt, bit 1 eq, bit 0 lt; exactly one bit is set for any operand pair.
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam cmp_res_t CMP_GT = 3'b100;
    localparam cmp_res_t CMP_EQ = 3'b010;
    localparam cmp_res_t CMP_LT = 3'b001;

endpackage

// File: rtl/rssi_band_sequencer_mag_cmp6.sv
// Combinational unsigned magnitude comparator; the single compare resource
// that the band sequencer time-shares across all thresholds.
module mag_cmp6
    import rssi_pkg::*;
#(
    parameter int W = RSSI_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output cmp_res_t     res
);

    always_comb begin
        res    = '0;
        res.gt = (a > b);
        res.eq = (a == b);
        res.lt = (a < b);
    end

endmodule

// File: rtl/rssi_band_sequencer.sv
// Steps each accepted RSSI sample through NUM_THR programmable thresholds with
// one shared comparator, then reports the band count, an equality flag and a debounced alarm.
module rssi_band_sequencer
    import rssi_pkg::*;
#(
    parameter int  W        = RSSI_W,
    parameter int  NUM_THR  = 4,
    parameter int  DEBOUNCE = 3,
    localparam int AW       = (NUM_THR > 1) ? $clog2(NUM_THR) : 1,
    localparam int IW       = $clog2(NUM_THR + 1),
    localparam int CW       = $clog2(DEBOUNCE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    input  logic          sample_valid,
    input  logic [W-1:0]  sample_data,
    output logic          sample_ready,
    output logic          busy,
    output logic          band_valid,
    output logic [IW-1:0] band_idx,
    output logic          band_eq,
    output logic          alarm
);

    state_t        state_q, state_d;
    logic [W-1:0]  thr_q [NUM_THR];
    logic [W-1:0]  thr_d [NUM_THR];
    logic [W-1:0]  sample_q, sample_d;
    logic [AW-1:0] k_q, k_d;
    logic [IW-1:0] acc_q, acc_d;
    logic          acc_eq_q, acc_eq_d;
    logic [IW-1:0] band_idx_q, band_idx_d;
    logic          band_eq_q, band_eq_d;
    logic          band_valid_q, band_valid_d;
    logic          busy_q, busy_d;
    logic          sample_ready_q, sample_ready_d;
    logic          alarm_q, alarm_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    cmp_res_t      res;
    logic          cmp_gt;
    logic          cmp_eq;
    logic          handshake;
    logic          last_k;
    logic [IW-1:0] acc_next;
    logic          eq_next;

    mag_cmp6 #(.W(W)) u_cmp (
        .a   (sample_q),
        .b   (thr_q[k_q]),
        .res (res)
    );

    // Decode the one-hot result as a whole word so an illegal code never counts.
    always_comb begin
        cmp_gt = 1'b0;
        cmp_eq = 1'b0;
        case (res)
            CMP_GT:  cmp_gt = 1'b1;
            CMP_EQ:  cmp_eq = 1'b1;
            default: ;
        endcase
    end

    // Out-of-range addresses match no entry, so they are dropped naturally.
    always_comb begin
        for (int k = 0; k < NUM_THR; k++) begin
            thr_d[k] = thr_q[k];
            if (cfg_we && (cfg_addr == AW'(k))) begin
                thr_d[k] = cfg_data;
            end
        end
    end

    always_comb begin
        handshake = sample_valid && sample_ready_q;
        last_k    = (k_q == AW'(NUM_THR - 1));
        acc_next  = (cmp_gt && (acc_q != IW'(NUM_THR))) ? acc_q + IW'(1) : acc_q;
        eq_next   = acc_eq_q | cmp_eq;

        state_d      = state_q;
        sample_d     = sample_q;
        k_d          = k_q;
        acc_d        = acc_q;
        acc_eq_d     = acc_eq_q;
        band_idx_d   = band_idx_q;
        band_eq_d    = band_eq_q;
        band_valid_d = 1'b0;
        alarm_d      = alarm_q;
        dcnt_d       = dcnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (handshake) begin
                    state_d  = CMP;
                    sample_d = sample_data;
                    k_d      = '0;
                    acc_d    = '0;
                    acc_eq_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CMP: begin
                acc_d    = acc_next;
                acc_eq_d = eq_next;
                k_d      = k_q + AW'(1);
                if (last_k) begin
                    state_d      = DONE;
                    band_valid_d = 1'b1;
                    band_idx_d   = acc_next;
                    band_eq_d    = eq_next;
                    acc_d        = '0;
                    acc_eq_d     = 1'b0;
                    k_d          = '0;
                    // Alarm is updated together with the result it is judged on.
                    if (acc_next == IW'(NUM_THR)) begin
                        if (dcnt_q != CW'(DEBOUNCE)) begin
                            dcnt_d = dcnt_q + CW'(1);
                        end
                        if (dcnt_d == CW'(DEBOUNCE)) begin
                            alarm_d = 1'b1;
                        end
                    end else if (acc_next == '0) begin
                        dcnt_d  = '0;
                        alarm_d = 1'b0;
                    end else begin
                        dcnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sample_ready_d = (state_d != CMP);
        busy_d         = (state_d == CMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            for (int k = 0; k < NUM_THR; k++) begin
                thr_q[k] <= '1;
            end
            k_q            <= '0;
            acc_q          <= '0;
            acc_eq_q       <= 1'b0;
            band_idx_q     <= '0;
            band_eq_q      <= 1'b0;
            band_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            sample_ready_q <= 1'b1;
            alarm_q        <= 1'b0;
            dcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            for (int k = 0; k < NUM_THR; k++) begin
                thr_q[k] <= thr_d[k];
            end
            k_q            <= k_d;
            acc_q          <= acc_d;
            acc_eq_q       <= acc_eq_d;
            band_idx_q     <= band_idx_d;
            band_eq_q      <= band_eq_d;
            band_valid_q   <= band_valid_d;
            busy_q         <= busy_d;
            sample_ready_q <= sample_ready_d;
            alarm_q        <= alarm_d;
            dcnt_q         <= dcnt_d;
        end
    end

    // Sample holding register carries data only and needs no reset.
    always_ff @(posedge clk) begin
        sample_q <= sample_d;
    end

    assign sample_ready = sample_ready_q;
    assign busy         = busy_q;
    assign band_valid   = band_valid_q;
    assign band_idx     = band_idx_q;
    assign band_eq      = band_eq_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_rssi_band_sequencer.sv
// Bench for rssi_band_sequencer: table vectors, multi-cycle corner sequences and
// randomized samples against a count-based reference model.
module tb_rssi_band_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       sample_valid;
    logic [5:0] sample_data;
    logic       sample_ready;
    logic       busy;
    logic       band_valid;
    logic [2:0] band_idx;
    logic       band_eq;
    logic       alarm;

    rssi_band_sequencer #(.W(6), .NUM_THR(4), .DEBOUNCE(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .busy         (busy),
        .band_valid   (band_valid),
        .band_idx     (band_idx),
        .band_eq      (band_eq),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: threshold values as written, and the alarm debounce count.
    int m_thr[4];
    int m_cnt;
    bit m_alarm;

    typedef struct {
        int thr[4];
        int s;
        int eidx;
        int eeq;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int t0, input int t1, input int t2, input int t3,
                                input int s, input int eidx, input int eeq);
        vec_t v;
        v.thr[0] = t0; v.thr[1] = t1; v.thr[2] = t2; v.thr[3] = t3;
        v.s = s; v.eidx = eidx; v.eeq = eeq;
        return v;
    endfunction

    // Threshold k is used in the (k+1)-th cycle after the handshake; a write
    // issued in cycle c is visible from cycle c+1, so it reaches threshold k iff c <= k.
    function automatic void ref_band(input int s, input int wr_cyc, input int wr_addr,
                                     input int wr_data, output int idx, output int eq);
        int t;
        idx = 0;
        eq  = 0;
        for (int k = 0; k < 4; k++) begin
            t = (wr_cyc >= 0 && wr_addr == k && wr_cyc <= k) ? wr_data : m_thr[k];
            if (s > t) idx++;
            if (s == t) eq = 1;
        end
    endfunction

    function automatic void model_alarm(input int idx);
        if (idx == 4) begin
            if (m_cnt < 3) m_cnt++;
            if (m_cnt == 3) m_alarm = 1'b1;
        end else if (idx == 0) begin
            m_cnt   = 0;
            m_alarm = 1'b0;
        end else begin
            m_cnt = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) m_thr[k] = 63;
        m_cnt   = 0;
        m_alarm = 1'b0;
    endfunction

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_data = 6'(d);
        @(posedge clk);
        @(negedge clk);
        cfg_we   = 1'b0;
        m_thr[a] = d;
    endtask

    // Starts and ends on a falling edge with the sequencer idle.
    task automatic run_sample(input int s, input int wr_cyc, input int wr_addr, input int wr_data,
                              output int a_idx, output int a_eq);
        int lat;
        int eidx;
        int eeq;
        logic [2:0] held;
        ref_band(s, wr_cyc, wr_addr, wr_data, eidx, eeq);
        check("ready_idle", sample_ready, 1);
        check("busy_idle", busy, 0);
        sample_valid = 1'b1;
        sample_data  = 6'(s);
        lat = -1;
        for (int c = 0; c <= 20; c++) begin
            if (c == wr_cyc) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'(wr_addr);
                cfg_data = 6'(wr_data);
            end
            @(posedge clk);
            @(negedge clk);
            cfg_we       = 1'b0;
            sample_valid = 1'b0;
            if (band_valid) begin
                lat = c + 1;
                break;
            end
        end
        if (wr_cyc >= 0) m_thr[wr_addr] = wr_data;
        model_alarm(eidx);
        check("latency", lat, 5);
        check("alarm", alarm, m_alarm);
        a_idx = band_idx;
        a_eq  = band_eq;
        held  = band_idx;
        @(posedge clk);
        @(negedge clk);
        check("valid_pulse", band_valid, 0);
        check("idx_hold", band_idx, held);
    endtask

    task automatic back_to_back();
        int accepts;
        int bvs;
        accepts = 0;
        bvs = 0;
        sample_valid = 1'b1;
        sample_data  = 6'd50;
        for (int c = 0; c < 40 && bvs < 3; c++) begin
            if (accepts == 3) sample_valid = 1'b0;
            if (band_valid) begin
                bvs++;
                model_alarm(4);
                check("b2b_period", c, 5 * bvs);
                check("b2b_idx", band_idx, 4);
                check("b2b_alarm", alarm, (bvs == 3) ? 1 : 0);
            end
            if (c > 0) check("b2b_ready", sample_ready, (c % 5 == 0) ? 1 : 0);
            if (sample_valid && sample_ready) accepts++;
            @(posedge clk);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("b2b_results", bvs, 3);
    endtask

    initial begin
        int aidx;
        int aeq;
        int eidx;
        int eeq;
        int s;
        int wc;
        int wa;
        int wd;
        int seen;

        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        sample_valid = 1'b0;
        sample_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", sample_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", band_valid, 0);
        check("rst_idx", band_idx, 0);
        check("rst_eq", band_eq, 0);
        check("rst_alarm", alarm, 0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = mk(63, 63, 63, 63, 63, 0, 1);
        vecs[1] = mk(10, 20, 30, 40, 25, 2, 0);
        vecs[2] = mk(10, 20, 30, 40, 40, 3, 1);
        vecs[3] = mk(10, 20, 30, 40, 0, 0, 0);
        vecs[4] = mk(10, 20, 30, 40, 63, 4, 0);
        vecs[5] = mk(10, 20, 30, 40, 10, 0, 1);
        vecs[6] = mk(10, 20, 30, 40, 41, 4, 0);
        vecs[7] = mk(40, 10, 30, 20, 35, 3, 0);
        vecs[8] = mk(40, 10, 30, 20, 20, 1, 1);
        vecs[9] = mk(40, 10, 30, 20, 9, 0, 0);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (m_thr[k] != vecs[i].thr[k]) cfg_write(k, vecs[i].thr[k]);
            end
            run_sample(vecs[i].s, -1, 0, 0, aidx, aeq);
            check($sformatf("vec%0d_idx", i), aidx, vecs[i].eidx);
            check($sformatf("vec%0d_eq", i), aeq, vecs[i].eeq);
        end

        // Ascending thresholds, debounce cleared by a bottom-band sample first.
        cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30); cfg_write(3, 40);
        run_sample(0, -1, 0, 0, aidx, aeq);
        check("pre_b2b_alarm", alarm, 0);
        back_to_back();

        run_sample(25, -1, 0, 0, aidx, aeq);
        check("hyst_hold", alarm, 1);
        run_sample(5, -1, 0, 0, aidx, aeq);
        check("hyst_clear", alarm, 0);
        run_sample(50, -1, 0, 0, aidx, aeq);
        run_sample(50, -1, 0, 0, aidx, aeq);
        check("debounce_two", alarm, 0);

        run_sample(25, 2, 1, 60, aidx, aeq);
        check("wr_collide_idx", aidx, 2);
        run_sample(25, -1, 0, 0, aidx, aeq);
        check("wr_after_idx", aidx, 1);
        cfg_write(1, 20);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2) == 0) cfg_write($urandom_range(3), $urandom_range(63));
            if ($urandom_range(1) == 0) s = (m_thr[$urandom_range(3)] + $urandom_range(2) + 63) % 64;
            else s = $urandom_range(63);
            if ($urandom_range(3) == 0) begin
                wc = $urandom_range(4);
                wa = $urandom_range(3);
                wd = $urandom_range(63);
            end else begin
                wc = -1;
                wa = 0;
                wd = 0;
            end
            ref_band(s, wc, wa, wd, eidx, eeq);
            run_sample(s, wc, wa, wd, aidx, aeq);
            check("rand_idx", aidx, eidx);
            check("rand_eq", aeq, eeq);
        end

        // Set the alarm, then reset in the middle of a comparison sequence.
        cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30); cfg_write(3, 40);
        for (int i = 0; i < 3; i++) run_sample(50, -1, 0, 0, aidx, aeq);
        check("pre_rst_alarm", alarm, 1);
        sample_valid = 1'b1;
        sample_data  = 6'd25;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", sample_ready, 1);
        check("mid_rst_alarm", alarm, 0);
        check("mid_rst_valid", band_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (band_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);
        run_sample(63, -1, 0, 0, aidx, aeq);
        check("thr_reload_idx", aidx, 0);
        check("thr_reload_eq", aeq, 1);
        run_sample(62, -1, 0, 0, aidx, aeq);
        check("thr_reload_idx2", aidx, 0);
        check("thr_reload_eq2", aeq, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
